// File: rtl/mult_job_arbiter.sv
// Round-robin arbiter/sequencer that shares one multiply/popcount engine between NREQ requesters.
// Latency: request seen in IDLE at k gives ready at k+1 and start at k+2; done at d gives rsp_valid at d+1; one job at a time.
module mult_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 24,
    parameter int WW      = 32,
    parameter int LW      = 6,
    parameter int TIMEOUT = 64,
    localparam int GW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_a1,
    input  logic [NREQ*AW-1:0]   req_a2,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [WW-1:0]        rsp_w,
    output logic [LW-1:0]        rsp_l,
    output logic                 rsp_ovf,
    output logic                 rsp_timeout,
    output logic                 eng_start,
    output logic [AW-1:0]        eng_a1,
    output logic [AW-1:0]        eng_a2,
    input  logic                 eng_done,
    input  logic [WW-1:0]        eng_w,
    input  logic [LW-1:0]        eng_l,
    input  logic                 eng_ovf,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic [15:0]          job_count
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   r_grant;
    logic [TW-1:0]   r_wdog;
    logic [AW-1:0]   r_a1;
    logic [AW-1:0]   r_a2;
    logic [WW-1:0]   r_rsp_w;
    logic [LW-1:0]   r_rsp_l;
    logic            r_rsp_ovf;
    logic            r_rsp_to;
    logic [15:0]     r_job_cnt;

    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_idx;
    logic            w_any;
    logic            w_granted_vld;
    logic            w_timeout;

    // Scan starting at the round-robin pointer; first requester found wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = GW'((int'(r_ptr) + i) % NREQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_granted_vld = req_valid[r_grant];
    assign w_timeout     = (r_wdog == WD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = w_granted_vld ? S_START : S_IDLE;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (eng_done || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_ISSUE: req_ready = NREQ'(1) << r_grant;
            S_START: eng_start = 1'b1;
            S_RESP:  rsp_valid = NREQ'(1) << r_grant;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_wdog    <= '0;
            r_a1      <= '0;
            r_a2      <= '0;
            r_rsp_w   <= '0;
            r_rsp_l   <= '0;
            r_rsp_ovf <= 1'b0;
            r_rsp_to  <= 1'b0;
            r_job_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any) r_grant <= w_pick;
                end
                S_ISSUE: begin
                    // A withdrawn request leaves operands and pointer untouched.
                    if (w_granted_vld) begin
                        r_a1 <= req_a1[r_grant*AW +: AW];
                        r_a2 <= req_a2[r_grant*AW +: AW];
                    end
                end
                S_START: begin
                    r_wdog <= '0;
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + TW'(1);
                    if (eng_done) begin
                        r_rsp_w   <= eng_w;
                        r_rsp_l   <= eng_l;
                        r_rsp_ovf <= eng_ovf;
                        r_rsp_to  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_w   <= '0;
                        r_rsp_l   <= '0;
                        r_rsp_ovf <= 1'b0;
                        r_rsp_to  <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_ptr     <= (r_grant == GW'(NREQ - 1)) ? '0 : r_grant + GW'(1);
                    r_job_cnt <= r_job_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign eng_a1      = r_a1;
    assign eng_a2      = r_a2;
    assign rsp_w       = r_rsp_w;
    assign rsp_l       = r_rsp_l;
    assign rsp_ovf     = r_rsp_ovf;
    assign rsp_timeout = r_rsp_to;
    assign grant_id    = r_grant;
    assign job_count   = r_job_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($countones({req_ready, rsp_valid, eng_start}) <= 1);
        end
    end

endmodule

// File: tb/tb_mult_job_arbiter.sv
// Bench for mult_job_arbiter: behavioural engine, round-robin model and response scoreboard.
module tb_mult_job_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [95:0] req_a1;
    logic [95:0] req_a2;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_w;
    logic [5:0]  rsp_l;
    logic        rsp_ovf;
    logic        rsp_timeout;
    logic        eng_start;
    logic [23:0] eng_a1;
    logic [23:0] eng_a2;
    logic        eng_done;
    logic [31:0] eng_w;
    logic [5:0]  eng_l;
    logic        eng_ovf;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] job_count;

    mult_job_arbiter #(.NREQ(4), .AW(24), .WW(32), .LW(6), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a1(req_a1), .req_a2(req_a2), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_w(rsp_w), .rsp_l(rsp_l), .rsp_ovf(rsp_ovf),
        .rsp_timeout(rsp_timeout), .eng_start(eng_start), .eng_a1(eng_a1), .eng_a2(eng_a2),
        .eng_done(eng_done), .eng_w(eng_w), .eng_l(eng_l), .eng_ovf(eng_ovf),
        .busy(busy), .grant_id(grant_id), .job_count(job_count)
    );

    typedef struct {
        int          g;
        logic [31:0] w;
        logic [5:0]  l;
        logic        ovf;
        logic        to;
    } sb_t;

    typedef struct {
        int          g;
        logic [23:0] a1;
        logic [23:0] a2;
        int          lat;
        logic [31:0] w;
        logic [5:0]  l;
        logic        ovf;
        logic        to;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  l;
        logic        ovf;
    } res_t;

    sb_t         sb[$];
    sb_t         mon_e;
    int          n_checks = 0;
    int          n_err    = 0;
    int          exp_ptr  = 0;
    logic [15:0] exp_jobs = '0;
    int          eng_lat  = 1;
    logic [23:0] op_a1[4];
    logic [23:0] op_a2[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (((m >> ((p + i) % 4)) & 4'd1) != 4'd0) return (p + i) % 4;
        end
        return 0;
    endfunction

    function automatic res_t golden(input logic [23:0] a1, input logic [23:0] a2);
        res_t        r;
        logic [47:0] p;
        p     = 48'(a1) * 48'(a2);
        r.w   = p[31:0];
        r.l   = 6'($countones(p[31:0]));
        r.ovf = |p[47:32];
        return r;
    endfunction

    // Behavioural engine: answers lat cycles after the start pulse, whatever the arbiter is doing by then.
    initial begin
        eng_done = 1'b0;
        eng_w    = '0;
        eng_l    = '0;
        eng_ovf  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (eng_start) begin
                res_t r;
                int   lat;
                r   = golden(eng_a1, eng_a2);
                lat = eng_lat;
                repeat (lat) @(posedge clk);
                #1;
                eng_done = 1'b1;
                eng_w    = r.w;
                eng_l    = r.l;
                eng_ovf  = r.ovf;
                @(posedge clk);
                #1;
                eng_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("onehot_strobes", 64'($countones({req_ready, rsp_valid, eng_start}) <= 1), 64'd1);
            if (rsp_valid != 4'd0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b with no job outstanding", rsp_valid);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(4'd1 << mon_e.g));
                    chk("rsp_w", 64'(rsp_w), 64'(mon_e.w));
                    chk("rsp_l", 64'(rsp_l), 64'(mon_e.l));
                    chk("rsp_ovf", 64'(rsp_ovf), 64'(mon_e.ovf));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.to));
                end
            end
        end
    end

    task automatic drive_ops();
        for (int i = 0; i < 4; i++) begin
            req_a1[i*24 +: 24] = op_a1[i];
            req_a2[i*24 +: 24] = op_a2[i];
        end
    endtask

    task automatic job(input logic [3:0] mask, input int lat, input bit hold,
                       input logic [31:0] ew, input logic [5:0] el, input logic eovf, input logic eto);
        int  g;
        int  n;
        sb_t e;
        g     = rr_pick(exp_ptr, mask);
        e.g   = g;
        e.w   = ew;
        e.l   = el;
        e.ovf = eovf;
        e.to  = eto;
        sb.push_back(e);
        eng_lat = lat;
        drive_ops();
        req_valid = mask;
        tick();
        chk("req_ready", 64'(req_ready), 64'(4'd1 << g));
        chk("grant_id", 64'(grant_id), 64'(g));
        tick();
        chk("eng_start", 64'(eng_start), 64'd1);
        chk("eng_a1", 64'(eng_a1), 64'(op_a1[g]));
        chk("eng_a2", 64'(eng_a2), 64'(op_a2[g]));
        if (!hold) req_valid[g] = 1'b0;
        n = 0;
        while (rsp_valid == 4'd0 && n < 200) begin
            tick();
            n++;
        end
        chk("rsp_latency", 64'(n), 64'(eto ? TIMEOUT + 1 : lat + 1));
        tick();
        exp_ptr  = (g + 1) % 4;
        exp_jobs = exp_jobs + 16'd1;
        chk("busy_after_job", 64'(busy), 64'd0);
        chk("job_count", 64'(job_count), 64'(exp_jobs));
        if (!hold) req_valid = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   exp_order[5];
        res_t r;
        int   g;

        tbl[0] = '{0, 24'd3,       24'd5,       4,  32'd15,         6'd4,  1'b0, 1'b0};
        tbl[1] = '{1, 24'hFFFFFF,  24'hFFFFFF,  2,  32'hFE000001,   6'd8,  1'b1, 1'b0};
        tbl[2] = '{2, 24'h000123,  24'h000010,  1,  32'h00001230,   6'd4,  1'b0, 1'b0};
        tbl[3] = '{3, 24'h010000,  24'h010000,  3,  32'h00000000,   6'd0,  1'b1, 1'b0};
        tbl[4] = '{2, 24'h00FFFF,  24'h00FFFF,  5,  32'hFFFE0001,   6'd16, 1'b0, 1'b0};
        tbl[5] = '{0, 24'h000000,  24'hABCDEF,  1,  32'h00000000,   6'd0,  1'b0, 1'b0};
        tbl[6] = '{1, 24'h001000,  24'h001000,  64, 32'h01000000,   6'd1,  1'b0, 1'b0};
        tbl[7] = '{3, 24'd5,       24'd6,       70, 32'h00000000,   6'd0,  1'b0, 1'b1};
        exp_order = '{0, 1, 2, 3, 0};

        reset     = 1'b1;
        req_valid = 4'd0;
        req_a1    = '0;
        req_a2    = '0;
        for (int i = 0; i < 4; i++) begin
            op_a1[i] = '0;
            op_a2[i] = '0;
        end
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_job_count", 64'(job_count), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_strobes", 64'({req_ready, rsp_valid, eng_start}), 64'd0);
        chk("rst_rsp", 64'({rsp_w, rsp_l, rsp_ovf, rsp_timeout}), 64'd0);
        chk("rst_eng_ops", 64'({eng_a1, eng_a2}), 64'd0);
        reset = 1'b0;
        tick();

        // Fairness: all four held high, grants must rotate.
        for (int i = 0; i < 4; i++) begin
            op_a1[i] = 24'(i + 2);
            op_a2[i] = 24'd7;
        end
        for (int k = 0; k < 5; k++) begin
            g = rr_pick(exp_ptr, 4'hF);
            r = golden(op_a1[g], op_a2[g]);
            job(4'hF, 3, 1'b1, r.w, r.l, r.ovf, 1'b0);
            chk("fair_order", 64'(grant_id), 64'(exp_order[k]));
        end
        req_valid = 4'd0;
        tick();

        // Table: single jobs incl. overflow, done on the timeout cycle, and a real timeout last.
        for (int k = 0; k < 8; k++) begin
            op_a1[tbl[k].g] = tbl[k].a1;
            op_a2[tbl[k].g] = tbl[k].a2;
            job(4'd1 << tbl[k].g, tbl[k].lat, 1'b0, tbl[k].w, tbl[k].l, tbl[k].ovf, tbl[k].to);
        end

        // Late done from the timed-out job must be ignored.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("late_done_no_rsp", 64'(rsp_valid), 64'd0);
            chk("late_done_idle", 64'(busy), 64'd0);
        end
        chk("timeout_flag_held", 64'(rsp_timeout), 64'd1);

        // Withdraw during ISSUE: back to IDLE, nothing started, pointer kept.
        op_a1[2] = 24'd11;
        op_a2[2] = 24'd13;
        drive_ops();
        req_valid = 4'b0100;
        tick();
        chk("wd_ready", 64'(req_ready), 64'h4);
        req_valid = 4'd0;
        tick();
        chk("wd_no_start", 64'(eng_start), 64'd0);
        chk("wd_idle", 64'(busy), 64'd0);
        chk("wd_job_count", 64'(job_count), 64'(exp_jobs));
        tick();
        op_a1[0] = 24'd9;
        op_a2[0] = 24'd9;
        g = rr_pick(exp_ptr, 4'hF);
        r = golden(op_a1[g], op_a2[g]);
        job(4'hF, 2, 1'b0, r.w, r.l, r.ovf, 1'b0);
        chk("wd_ptr_kept", 64'(grant_id), 64'd0);

        // Reset while waiting on the engine.
        op_a1[1] = 24'd7;
        op_a2[1] = 24'd9;
        drive_ops();
        eng_lat   = 10;
        req_valid = 4'b0010;
        tick();
        chk("rw_ready", 64'(req_ready), 64'h2);
        tick();
        chk("rw_start", 64'(eng_start), 64'd1);
        req_valid = 4'd0;
        tick();
        tick();
        tick();
        chk("rw_busy_wait", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_job_count", 64'(job_count), 64'd0);
        chk("rw_grant_id", 64'(grant_id), 64'd0);
        chk("rw_rsp", 64'({rsp_w, rsp_l, rsp_ovf, rsp_timeout}), 64'd0);
        chk("rw_eng_ops", 64'({eng_a1, eng_a2}), 64'd0);
        exp_ptr  = 0;
        exp_jobs = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rw_no_rsp", 64'(rsp_valid), 64'd0);
            chk("rw_idle", 64'(busy), 64'd0);
        end

        op_a1[2] = 24'h800000;
        op_a2[2] = 24'd2;
        job(4'b0100, 2, 1'b0, 32'h01000000, 6'd1, 1'b0, 1'b0);
        repeat (3) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
